// File: rtl/snake_pkg.sv
// Shared definitions for the frame write controller.
// Holds the parser and executor state encodings, header opcodes, default
// frame geometry and the command-buffer record. The record fields are sized
// for the widest supported configuration; users truncate to their widths.
package snake_pkg;

    localparam int DEF_COLS   = 40;
    localparam int DEF_ROWS   = 30;
    localparam int CMD_ADDR_W = 16;
    localparam int CMD_VAL_W  = 8;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b01;

    typedef enum logic [1:0] {
        P_HDR = 2'd0,
        P_X   = 2'd1,
        P_Y   = 2'd2
    } parse_state_t;

    typedef enum logic [1:0] {
        E_IDLE  = 2'd0,
        E_WRITE = 2'd1,
        E_CLEAR = 2'd2
    } exec_state_t;

    typedef struct packed {
        logic [1:0]            kind;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_VAL_W-1:0]  value;
    } cmd_t;

endpackage

// File: rtl/spi_packet_parser.sv
// SPI packet parser: turns header/x/y bytes into WRITE and CLEAR commands.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   cs, rx_byte,        SPI chip-select and received byte with its
//   rx_valid            one-cycle valid strobe
//   cmd_valid           command completes this cycle (combinational)
//   cmd_kind            OP_WRITE / OP_CLEAR
//   cmd_addr            y*COLS+x for WRITE
//   cmd_value           tile value (WRITE data or CLEAR fill)
//   err_range           one-cycle pulse after an out-of-range WRITE
module spi_packet_parser
    import snake_pkg::*;
#(
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int ADDR_W = 11,
    parameter int TILE_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    output logic              cmd_valid,
    output logic [1:0]        cmd_kind,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [TILE_W-1:0] cmd_value,
    output logic              err_range
);

    parse_state_t state_r;
    parse_state_t state_next_s;
    logic [7:0]   x_r;
    logic [3:0]   hdr_value_r;
    logic         err_range_r;
    logic         range_bad_s;
    logic         accept_s;
    logic         in_range_s;

    assign accept_s   = rx_valid & cs;
    // In P_Y the incoming byte is y; the range test uses the full bytes.
    assign in_range_s = (32'(x_r) < COLS) && (32'(rx_byte) < ROWS);
    assign cmd_addr   = (ADDR_W'(rx_byte[4:0]) * ADDR_W'(COLS)) + ADDR_W'(x_r[5:0]);
    // A CLEAR completes on its header byte, so the fill comes straight from it.
    assign cmd_value  = (state_r == P_HDR) ? TILE_W'(rx_byte[3:0]) : TILE_W'(hdr_value_r);
    assign err_range  = err_range_r;

    // Next-state and command-completion decode.
    always_comb begin
        state_next_s = state_r;
        cmd_valid    = 1'b0;
        cmd_kind     = OP_WRITE;
        range_bad_s  = 1'b0;
        case (state_r)
            P_HDR: begin
                if (accept_s && (rx_byte[7:6] == OP_WRITE)) begin
                    state_next_s = P_X;
                end else if (accept_s && (rx_byte[7:6] == OP_CLEAR)) begin
                    cmd_valid = 1'b1;
                    cmd_kind  = OP_CLEAR;
                end else begin
                    state_next_s = P_HDR;
                end
            end
            P_X: begin
                if (!cs) begin
                    state_next_s = P_HDR;
                end else if (rx_valid) begin
                    state_next_s = P_Y;
                end else begin
                    state_next_s = P_X;
                end
            end
            P_Y: begin
                if (!cs) begin
                    state_next_s = P_HDR;
                end else if (rx_valid) begin
                    state_next_s = P_HDR;
                    if (in_range_s) begin
                        cmd_valid = 1'b1;
                    end else begin
                        range_bad_s = 1'b1;
                    end
                end else begin
                    state_next_s = P_Y;
                end
            end
            default: begin
                state_next_s = P_HDR;
            end
        endcase
    end

    // Parser state, captured header value and x byte, range-error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= P_HDR;
            x_r         <= 8'd0;
            hdr_value_r <= 4'd0;
            err_range_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            err_range_r <= range_bad_s;
            if ((state_r == P_HDR) && accept_s) begin
                hdr_value_r <= rx_byte[3:0];
            end
            if ((state_r == P_X) && accept_s) begin
                x_r <= rx_byte;
            end
        end
    end

endmodule

// File: rtl/frame_write_ctrl.sv
// Frame write controller: SPI packets -> one-entry command buffer -> tile
// memory write executor (single writes and full-frame clears).
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   cs, rx_byte, rx_valid SPI byte stream
//   mem_ready             memory write port available this cycle
//   mem_we, mem_addr,     tile-memory write port
//   mem_wdata
//   busy                  buffer occupied or executor active
//   err_range             pulse: out-of-range WRITE dropped
//   err_overflow          pulse: completed command dropped, buffer full
module frame_write_ctrl
    import snake_pkg::*;
#(
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int ADDR_W = 11,
    parameter int TILE_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [TILE_W-1:0] mem_wdata,
    output logic              busy,
    output logic              err_range,
    output logic              err_overflow
);

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(COLS * ROWS - 1);

    logic              cmd_valid_s;
    logic [1:0]        cmd_kind_s;
    logic [ADDR_W-1:0] cmd_addr_s;
    logic [TILE_W-1:0] cmd_value_s;

    cmd_t              cmd_buf_r;
    logic              buf_valid_r;
    logic              pop_s;
    logic              push_s;
    logic              ovf_s;
    logic              err_overflow_r;

    exec_state_t       exec_r;
    exec_state_t       exec_next_s;
    logic [ADDR_W-1:0] cur_addr_r;
    logic [TILE_W-1:0] cur_value_r;
    logic [ADDR_W-1:0] clr_addr_r;

    spi_packet_parser #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W),
        .TILE_W (TILE_W)
    ) u_parser (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .cmd_valid (cmd_valid_s),
        .cmd_kind  (cmd_kind_s),
        .cmd_addr  (cmd_addr_s),
        .cmd_value (cmd_value_s),
        .err_range (err_range)
    );

    // A new command may take the slot in the same cycle the old one leaves.
    assign push_s       = cmd_valid_s && (!buf_valid_r || pop_s);
    assign ovf_s        = cmd_valid_s && !push_s;
    assign busy         = buf_valid_r || (exec_r != E_IDLE);
    assign err_overflow = err_overflow_r;

    // Executor next-state, buffer pop and memory port drive.
    always_comb begin
        exec_next_s = exec_r;
        pop_s       = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (exec_r)
            E_IDLE: begin
                if (buf_valid_r) begin
                    pop_s       = 1'b1;
                    exec_next_s = (cmd_buf_r.kind == OP_CLEAR) ? E_CLEAR : E_WRITE;
                end else begin
                    exec_next_s = E_IDLE;
                end
            end
            E_WRITE: begin
                mem_we    = mem_ready;
                mem_addr  = cur_addr_r;
                mem_wdata = cur_value_r;
                if (mem_ready) begin
                    exec_next_s = E_IDLE;
                end else begin
                    exec_next_s = E_WRITE;
                end
            end
            E_CLEAR: begin
                mem_we    = mem_ready;
                mem_addr  = clr_addr_r;
                mem_wdata = cur_value_r;
                if (mem_ready && (clr_addr_r == CLR_LAST)) begin
                    exec_next_s = E_IDLE;
                end else begin
                    exec_next_s = E_CLEAR;
                end
            end
            default: begin
                exec_next_s = E_IDLE;
            end
        endcase
    end

    // One-entry command buffer and overflow pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_buf_r      <= '0;
            buf_valid_r    <= 1'b0;
            err_overflow_r <= 1'b0;
        end else begin
            err_overflow_r <= ovf_s;
            if (push_s) begin
                cmd_buf_r.kind  <= cmd_kind_s;
                cmd_buf_r.addr  <= CMD_ADDR_W'(cmd_addr_s);
                cmd_buf_r.value <= CMD_VAL_W'(cmd_value_s);
                buf_valid_r     <= 1'b1;
            end else if (pop_s) begin
                buf_valid_r <= 1'b0;
            end
        end
    end

    // Executor state, latched command and clear address counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exec_r      <= E_IDLE;
            cur_addr_r  <= '0;
            cur_value_r <= '0;
            clr_addr_r  <= '0;
        end else begin
            exec_r <= exec_next_s;
            if (pop_s) begin
                cur_addr_r  <= ADDR_W'(cmd_buf_r.addr);
                cur_value_r <= TILE_W'(cmd_buf_r.value);
                clr_addr_r  <= '0;
            end else if ((exec_r == E_CLEAR) && mem_ready) begin
                clr_addr_r <= clr_addr_r + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_frame_write_ctrl.sv
// Scoreboard bench for frame_write_ctrl: stimulus pushes expected memory
// writes into a queue, a negedge monitor pops and compares each write.
module tb_frame_write_ctrl;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        cs        = 1'b0;
    logic [7:0]  rx_byte   = 8'd0;
    logic        rx_valid  = 1'b0;
    logic        mem_ready = 1'b1;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [3:0]  mem_wdata;
    logic        busy;
    logic        err_range;
    logic        err_overflow;

    typedef struct {
        int addr;
        int data;
        int at;
    } exp_t;

    exp_t q[$];
    int   cyc       = 0;
    int   checks    = 0;
    int   errors    = 0;
    int   range_cnt = 0;
    int   ovf_cnt   = 0;
    int   last_cyc  = 0;
    bit   toggle_en = 1'b0;

    frame_write_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .cs           (cs),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .mem_ready    (mem_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .err_range    (err_range),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // mem_ready: constant high, or alternating 1/0 while toggle_en is set.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) mem_ready = ~mem_ready;
            else           mem_ready = 1'b1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (mem_we) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%0d expected no write", mem_addr, mem_wdata);
            end else begin
                e = q.pop_front();
                chk("wr_addr", int'(mem_addr), e.addr);
                chk("wr_data", int'(mem_wdata), e.data);
                if (e.at >= 0) chk("wr_cycle", cyc, e.at);
            end
        end
        if (err_range)    range_cnt++;
        if (err_overflow) ovf_cnt++;
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_byte  = b;
        rx_valid = 1'b1;
        last_cyc = cyc;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic push_clear(input int data);
        for (int i = 0; i < 1200; i++) q.push_back('{i, data, -1});
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout_busy", int'(busy), 0);
    endtask

    initial begin
        bit found;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err_range", int'(err_range), 0);
        chk("rst_err_overflow", int'(err_overflow), 0);
        reset = 1'b0;
        cs    = 1'b1;

        // Single write x=3 y=2 v=5 -> addr 83, two cycles after the y byte.
        send(8'h05);
        send(8'h03);
        send(8'h02);
        q.push_back('{83, 5, last_cyc + 2});
        wait_idle(50);
        chk("s1_queue_empty", q.size(), 0);

        // x=40 is out of range: no write, one err_range pulse.
        send(8'h07);
        send(8'h28);
        send(8'h00);
        repeat (4) @(posedge clk);
        #1;
        chk("s2_range_pulses", range_cnt, 1);
        chk("s2_busy", int'(busy), 0);

        // CLEAR with fill 9 under a toggling mem_ready.
        toggle_en = 1'b1;
        send(8'h49);
        push_clear(9);
        wait_idle(5000);
        toggle_en = 1'b0;
        chk("s3_queue_empty", q.size(), 0);

        // Two writes during a CLEAR: first buffered, second overflows.
        send(8'h41);
        push_clear(1);
        send(8'h02);
        send(8'h01);
        send(8'h00);
        q.push_back('{1, 2, -1});
        send(8'h03);
        send(8'h02);
        send(8'h00);
        wait_idle(3000);
        chk("s4_queue_empty", q.size(), 0);
        chk("s4_ovf_pulses", ovf_cnt, 1);
        chk("s4_range_pulses", range_cnt, 1);

        // Partial packet aborted by cs low, then x=4 y=1 v=5 -> addr 44.
        send(8'h05);
        send(8'h03);
        @(posedge clk);
        #1;
        cs = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        cs = 1'b1;
        send(8'h05);
        send(8'h04);
        send(8'h01);
        q.push_back('{44, 5, -1});
        wait_idle(50);
        chk("s5_queue_empty", q.size(), 0);
        chk("s5_range_pulses", range_cnt, 1);

        // Reset in the middle of a CLEAR at address 500.
        send(8'h43);
        push_clear(3);
        found = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (mem_we && (mem_addr == 11'd500)) begin
                found = 1'b1;
                break;
            end
        end
        chk("s6_reached_500", int'(found), 1);
        #1;
        reset = 1'b1;
        #1;
        chk("s6_mem_we_reset", int'(mem_we), 0);
        chk("s6_busy_reset", int'(busy), 0);
        q.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("s6_busy_after", int'(busy), 0);
        chk("s6_ovf_pulses", ovf_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_write_ctrl.md
FRAME_WRITE_CTRL -- requirements
Module: frame_write_ctrl

Interface
REQ-001 Parameter COLS, default 40, tile columns.
REQ-002 Parameter ROWS, default 30, tile rows.
REQ-003 Parameter ADDR_W, default 11, tile-memory address width.
REQ-004 Parameter TILE_W, default 4, tile value width.
REQ-005 clk  in  1  single system clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 cs  in  1  SPI chip-select, high = transaction active.
REQ-008 rx_byte  in  8  received SPI byte.
REQ-009 rx_valid  in  1  one-cycle pulse, rx_byte valid.
REQ-010 mem_ready  in  1  tile-memory write port available this cycle.
REQ-011 mem_we  out  1  tile-memory write enable.
REQ-012 mem_addr  out  ADDR_W  write address, y*COLS+x.
REQ-013 mem_wdata  out  TILE_W  write data.
REQ-014 busy  out  1  high while buffer occupied or executor not idle.
REQ-015 err_range  out  1  one-cycle pulse, out-of-range write dropped.
REQ-016 err_overflow  out  1  one-cycle pulse, completed command dropped.

Function
REQ-017 Parser states P_HDR, P_X, P_Y; bytes are consumed only on rx_valid while cs is high.
REQ-018 Header byte bits[7:6]: 00 = WRITE, 01 = CLEAR, 10/11 = ignored (parser stays in P_HDR); bits[3:0] = tile value.
REQ-019 WRITE: P_HDR -> P_X -> P_Y, then P_HDR; the command completes on the cycle the y byte is accepted.
REQ-020 CLEAR: completes on the cycle the header byte is accepted; the parser stays in P_HDR.
REQ-021 Deasserting cs in P_X or P_Y discards the partial packet and returns the parser to P_HDR next cycle, with no error pulse.
REQ-022 A WRITE with x >= COLS or y >= ROWS is dropped, and err_range pulses the cycle after completion.
REQ-023 Address arithmetic: x and y are truncated to 6 and 5 bits, and y*COLS+x is computed at ADDR_W bits.
REQ-024 One-entry command buffer {kind, addr, value}: a completed command is stored if the buffer is empty or is being popped the same cycle.
REQ-025 Otherwise the completed command is dropped, and err_overflow pulses the next cycle.
REQ-026 Executor states E_IDLE, E_WRITE, E_CLEAR: in E_IDLE with the buffer valid, it pops the buffer and enters E_WRITE or E_CLEAR next cycle.
REQ-027 E_WRITE: mem_we = mem_ready; returns to E_IDLE the cycle after a write with mem_ready high.
REQ-028 Latency: y byte accepted at cycle N gives the earliest mem_we at N+2, with an empty pipeline and mem_ready high.
REQ-029 E_CLEAR: mem_we = mem_ready, mem_wdata = fill value, and the address starts at 0 and increments only on cycles with mem_ready high.
REQ-030 E_CLEAR: after writing COLS*ROWS-1, the executor returns to E_IDLE.
REQ-031 mem_we is never high outside E_WRITE/E_CLEAR; mem_addr/mem_wdata are don't-care when mem_we is low.
REQ-032 Commands execute strictly in arrival order, with no preemption of an active CLEAR.

Reset
REQ-033 Reset forces P_HDR, E_IDLE, buffer empty, clear counter 0, and mem_we/busy/err_range/err_overflow to 0 immediately.
REQ-034 Reset mid-CLEAR or mid-packet abandons the operation; no write occurs after reset deasserts until a new command completes.

Structure
REQ-035 The shared package snake_pkg holds the parser and executor state enums, opcode constants, COLS/ROWS defaults and the command-buffer struct.
REQ-036 The design has one sub-module, spi_packet_parser (REQ-017..023); buffer and executor stay in frame_write_ctrl.

Verification
REQ-037 Scenario: cs=1, bytes 0x05,0x03,0x02, mem_ready=1 -> single mem_we, addr 83, data 5, at y-byte cycle+2.
REQ-038 Scenario: bytes 0x07,0x28,0x00 (x=40) -> no mem_we, one err_range pulse.
REQ-039 Scenario: header 0x49 with mem_ready toggling 1/0 -> exactly 1200 writes of data 9, addresses 0..1199 in order, busy low after.
REQ-040 Scenario: during CLEAR, send WRITE(x=1,y=0,v=2) then WRITE(x=2,y=0,v=3) -> first buffered, executes after address 1199 write; second gives err_overflow.
REQ-041 Scenario: 0x05,0x03, then cs low, then 0x05,0x04,0x01 -> only one write, addr 44, data 5.
REQ-042 Scenario: reset asserted at clear address 500 -> mem_we low immediately; no further writes; busy 0.
